// File: rtl/saxis_pattern_checker.sv
// -----------------------------------------------------------------------------
// saxis_pattern_checker
//
// AXI4-Stream sink that checks a synthetic video test pattern. Each 32-bit
// word carries four pixels. The expected word at (frame, line, word) is
// {frame[3:0], line[11:0], 16'h0} + word, computed as a 32-bit add that wraps.
// The checker stays idle for C_S_START_COUNT cycles after reset. It then
// hunts for a start-of-frame beat (USER=1), locks onto the frame nibble that
// beat carries, and from then on checks every accepted beat for data and
// framing errors.
//
// Optional feature (compile-time macro SAXIS_BACKPRESSURE_EN):
//   When defined, an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01) stalls TREADY
//   whenever lfsr[1:0] == 2'b00. When undefined, TREADY is constant 1 outside
//   IDLE.
//
// Ports:
//   S_AXIS_ACLK     in   clock
//   S_AXIS_ARESETN  in   asynchronous active-low reset
//   S_AXIS_TVALID   in   beat valid
//   S_AXIS_TREADY   out  checker accepts the beat
//   S_AXIS_TDATA    in   pattern word
//   S_AXIS_TSTRB    in   byte qualifiers (ignored)
//   S_AXIS_TLAST    in   end of line
//   S_AXIS_USER     in   start of frame
//   clear           in   synchronous pulse; zeroes all counters and flags
//   locked          out  high while in CHECK
//   frame_done      out  one-cycle pulse after the last word of a frame
//   frames_ok       out  error-free complete frames (saturating)
//   data_err_cnt    out  TDATA mismatches (saturating)
//   sync_err_cnt    out  TLAST/USER framing errors (saturating)
//   err_flag        out  sticky error flag
// -----------------------------------------------------------------------------
module saxis_pattern_checker #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_S_START_COUNT      = 3,
  parameter int PIXELS_HORIZONTAL    = 1280,
  parameter int PIXELS_VERTICAL      = 1024
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESETN,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_USER,
  input  logic                                clear,
  output logic                                locked,
  output logic                                frame_done,
  output logic [15:0]                         frames_ok,
  output logic [15:0]                         data_err_cnt,
  output logic [15:0]                         sync_err_cnt,
  output logic                                err_flag
);

  localparam int WORDS   = PIXELS_HORIZONTAL / 4;
  localparam int WORD_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LINE_W  = (PIXELS_VERTICAL > 1) ? $clog2(PIXELS_VERTICAL) : 1;
  localparam int START_W = (C_S_START_COUNT > 1) ? $clog2(C_S_START_COUNT) : 1;

  localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(WORDS - 1);
  localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(PIXELS_VERTICAL - 1);
  localparam logic [START_W-1:0] START_LAST =
    START_W'((C_S_START_COUNT > 0) ? (C_S_START_COUNT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SYNC  = 2'b01,
    ST_CHECK = 2'b10
  } state_t;

  // Saturating 16-bit increment used by every statistics counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc16 = v;
    end else begin
      sat_inc16 = v + 16'd1;
    end
  endfunction

  // Pattern word expected at a given position; the add wraps modulo 2^32.
  function automatic logic [31:0] expected_word(input logic [3:0]  f,
                                                input logic [11:0] l,
                                                input logic [31:0] w);
    expected_word = {f, l, 16'h0000} + w;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t              state_r, state_nx_s;
  logic [START_W-1:0]  start_cnt_r, start_cnt_nx_s;
  logic [3:0]          exp_frame_r, exp_frame_nx_s;
  logic [LINE_W-1:0]   exp_line_r, exp_line_nx_s;
  logic [WORD_W-1:0]   word_r, word_nx_s;
  logic                frame_bad_r, frame_bad_nx_s;

  logic                tready_r;
  logic                locked_r;
  logic                frame_done_r;
  logic [15:0]         frames_ok_r;
  logic [15:0]         data_err_cnt_r;
  logic [15:0]         sync_err_cnt_r;
  logic                err_flag_r;

  // ---------------------------------------------------------------------------
  // Per-beat evaluation signals
  // ---------------------------------------------------------------------------
  logic [31:0]         tdata_s;
  logic                beat_acc_s;
  logic                check_beat_s;
  logic [3:0]          chk_frame_s;
  logic [LINE_W-1:0]   chk_line_s;
  logic [WORD_W-1:0]   chk_word_s;
  logic                last_word_s;
  logic                first_beat_s;
  logic                data_err_s;
  logic                sync_err_s;
  logic                frame_end_s;
  logic                frame_bad_prev_s;
  logic                frame_good_s;
  logic                stall_nx_s;
  logic                unused_s;

  assign tdata_s    = S_AXIS_TDATA[31:0];
  // Byte qualifiers carry no information for this pattern.
  assign unused_s   = ^S_AXIS_TSTRB;
  assign beat_acc_s = S_AXIS_TVALID & tready_r;

`ifdef SAXIS_BACKPRESSURE_EN
  logic [7:0] lfsr_r;
  logic [7:0] lfsr_nx_s;

  assign lfsr_nx_s  = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  // TREADY is registered, so the stall decision looks at the next LFSR value.
  assign stall_nx_s = (lfsr_nx_s[1:0] == 2'b00);

  // Free-running LFSR that drives the pseudo-random stalls.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      lfsr_r <= 8'h01;
    end else begin
      lfsr_r <= lfsr_nx_s;
    end
  end
`else
  assign stall_nx_s = 1'b0;
`endif

  // Select the position an accepted beat is checked against. A SOF beat
  // seen in SYNC is checked as line 0, word 0 of the frame it announces.
  always_comb begin
    check_beat_s = 1'b0;
    chk_frame_s  = exp_frame_r;
    chk_line_s   = exp_line_r;
    chk_word_s   = word_r;
    case (state_r)
      ST_SYNC: begin
        if (beat_acc_s && S_AXIS_USER) begin
          check_beat_s = 1'b1;
          chk_frame_s  = tdata_s[31:28];
          chk_line_s   = {LINE_W{1'b0}};
          chk_word_s   = {WORD_W{1'b0}};
        end else begin
          check_beat_s = 1'b0;
        end
      end
      ST_CHECK: check_beat_s = beat_acc_s;
      default:  check_beat_s = 1'b0;
    endcase
  end

  // Data and framing error detection for the beat being checked.
  always_comb begin
    data_err_s   = 1'b0;
    sync_err_s   = 1'b0;
    last_word_s  = (chk_word_s == WORD_LAST);
    first_beat_s = (chk_line_s == {LINE_W{1'b0}}) && (chk_word_s == {WORD_W{1'b0}});
    if (check_beat_s) begin
      data_err_s = (tdata_s != expected_word(chk_frame_s, 12'(chk_line_s), 32'(chk_word_s)));
      sync_err_s = (S_AXIS_TLAST != last_word_s) || (S_AXIS_USER != first_beat_s);
    end else begin
      data_err_s = 1'b0;
      sync_err_s = 1'b0;
    end
  end

  // FSM next state and position advance. A framing error drops back to
  // SYNC, and the offending beat never counts as a fresh SOF.
  always_comb begin
    state_nx_s     = state_r;
    start_cnt_nx_s = start_cnt_r;
    exp_frame_nx_s = exp_frame_r;
    exp_line_nx_s  = exp_line_r;
    word_nx_s      = word_r;
    frame_end_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_cnt_r >= START_LAST) begin
          state_nx_s = ST_SYNC;
        end else begin
          start_cnt_nx_s = start_cnt_r + START_W'(1);
        end
      end
      ST_SYNC, ST_CHECK: begin
        if (check_beat_s) begin
          if (sync_err_s) begin
            state_nx_s = ST_SYNC;
          end else begin
            state_nx_s     = ST_CHECK;
            exp_frame_nx_s = chk_frame_s;
            if (last_word_s) begin
              word_nx_s = {WORD_W{1'b0}};
              if (chk_line_s == LINE_LAST) begin
                exp_line_nx_s  = {LINE_W{1'b0}};
                exp_frame_nx_s = chk_frame_s + 4'd1;
                frame_end_s    = 1'b1;
              end else begin
                exp_line_nx_s = chk_line_s + LINE_W'(1);
              end
            end else begin
              word_nx_s     = chk_word_s + WORD_W'(1);
              exp_line_nx_s = chk_line_s;
            end
          end
        end else begin
          state_nx_s = state_r;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Per-frame error tracking. A frame starts clean at its SOF, either on
  // lock or when the previous frame completes while still in CHECK.
  always_comb begin
    frame_bad_prev_s = (state_r == ST_CHECK) ? frame_bad_r : 1'b0;
    frame_bad_nx_s   = frame_bad_r;
    frame_good_s     = frame_end_s && !(frame_bad_prev_s || data_err_s);
    if (check_beat_s) begin
      if (frame_end_s) begin
        frame_bad_nx_s = 1'b0;
      end else begin
        frame_bad_nx_s = frame_bad_prev_s | data_err_s | sync_err_s;
      end
    end else begin
      frame_bad_nx_s = frame_bad_r;
    end
  end

  // FSM state, position and registered handshake/status outputs.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_r      <= ST_IDLE;
      start_cnt_r  <= {START_W{1'b0}};
      exp_frame_r  <= 4'h0;
      exp_line_r   <= {LINE_W{1'b0}};
      word_r       <= {WORD_W{1'b0}};
      tready_r     <= 1'b0;
      locked_r     <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      start_cnt_r  <= start_cnt_nx_s;
      exp_frame_r  <= exp_frame_nx_s;
      exp_line_r   <= exp_line_nx_s;
      word_r       <= word_nx_s;
      tready_r     <= (state_nx_s != ST_IDLE) && !stall_nx_s;
      locked_r     <= (state_nx_s == ST_CHECK);
      frame_done_r <= frame_end_s;
    end
  end

  // Statistics counters and sticky flags; clear wins over a same-cycle error.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      frame_bad_r    <= 1'b0;
      frames_ok_r    <= 16'h0000;
      data_err_cnt_r <= 16'h0000;
      sync_err_cnt_r <= 16'h0000;
      err_flag_r     <= 1'b0;
    end else if (clear) begin
      frame_bad_r    <= 1'b0;
      frames_ok_r    <= 16'h0000;
      data_err_cnt_r <= 16'h0000;
      sync_err_cnt_r <= 16'h0000;
      err_flag_r     <= 1'b0;
    end else begin
      frame_bad_r <= frame_bad_nx_s;
      if (data_err_s) begin
        data_err_cnt_r <= sat_inc16(data_err_cnt_r);
      end
      if (sync_err_s) begin
        sync_err_cnt_r <= sat_inc16(sync_err_cnt_r);
      end
      if (data_err_s || sync_err_s) begin
        err_flag_r <= 1'b1;
      end
      if (frame_good_s) begin
        frames_ok_r <= sat_inc16(frames_ok_r);
      end
    end
  end

  assign S_AXIS_TREADY = tready_r;
  assign locked        = locked_r;
  assign frame_done    = frame_done_r;
  assign frames_ok     = frames_ok_r;
  assign data_err_cnt  = data_err_cnt_r;
  assign sync_err_cnt  = sync_err_cnt_r;
  assign err_flag      = err_flag_r;

endmodule

// File: tb/tb_saxis_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_saxis_pattern_checker
//
// Self-checking bench for saxis_pattern_checker (WORDS=4, 4 lines, start
// count 3). Beats are queued as whole frames, with optional corruption. A
// behavioural model predicts every output in every cycle from the linear beat
// position inside the frame. Literal checks after each directed phase pin the
// model.
// -----------------------------------------------------------------------------
module tb_saxis_pattern_checker;

  localparam int PH    = 16;
  localparam int PV    = 4;
  localparam int START = 3;
  localparam int WORDS = PH / 4;

  logic        clk;
  logic        rst_n;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tuser;
  logic        clr;
  logic        locked;
  logic        frame_done;
  logic [15:0] frames_ok;
  logic [15:0] data_err_cnt;
  logic [15:0] sync_err_cnt;
  logic        err_flag;

  saxis_pattern_checker #(
    .C_S_AXIS_TDATA_WIDTH(32),
    .C_S_START_COUNT(START),
    .PIXELS_HORIZONTAL(PH),
    .PIXELS_VERTICAL(PV)
  ) dut (
    .S_AXIS_ACLK(clk),
    .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready),
    .S_AXIS_TDATA(tdata),
    .S_AXIS_TSTRB(tstrb),
    .S_AXIS_TLAST(tlast),
    .S_AXIS_USER(tuser),
    .clear(clr),
    .locked(locked),
    .frame_done(frame_done),
    .frames_ok(frames_ok),
    .data_err_cnt(data_err_cnt),
    .sync_err_cnt(sync_err_cnt),
    .err_flag(err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic        user;
  } beat_t;

  beat_t q[$];
  beat_t cur;
  bit    have_cur;
  int    gap_pct;

  int total;
  int bad;
  int dut_done;

  // Model state: mode 0=idle, 1=hunting for SOF, 2=checking.
  int   m_mode, m_idle, m_frame, m_pos;
  int   m_frames_ok, m_derr, m_serr, m_done_total;
  bit   m_err, m_bad;
  logic e_tready, e_locked, e_done;
  logic [7:0] m_lfsr;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function void model_reset();
    m_mode = 0; m_idle = 0; m_frame = 0; m_pos = 0;
    m_frames_ok = 0; m_derr = 0; m_serr = 0;
    m_err = 1'b0; m_bad = 1'b0;
    e_tready = 1'b0; e_locked = 1'b0; e_done = 1'b0;
    m_lfsr = 8'h01;
  endfunction

  // Advance the model by one clock using the inputs presented this cycle.
  function void model_step(input bit v, input logic [31:0] d, input bit last,
                           input bit user, input bit c);
    bit acc, de, se, done, ok;
    int nmode, line, word;
    logic [31:0] exp;
    acc = v && e_tready;
    de = 0; se = 0; done = 0; ok = 0;
    nmode = m_mode;
    if (m_mode == 0) begin
      m_idle++;
      if (m_idle >= START) nmode = 1;
    end else if (acc && (m_mode == 2 || user)) begin
      if (m_mode == 1) begin
        m_frame = int'(d[31:28]);
        m_pos = 0;
        m_bad = 0;
      end
      line = m_pos / WORDS;
      word = m_pos % WORDS;
      exp  = {4'(m_frame), 12'(line), 16'h0000} + 32'(word);
      de   = (d !== exp);
      se   = (last != (word == WORDS - 1)) || (user != (m_pos == 0));
      if (se) begin
        nmode = 1;
        m_bad = 1;
      end else begin
        nmode = 2;
        ok = !(m_bad || de);
        if (de) m_bad = 1;
        m_pos++;
        if (m_pos == WORDS * PV) begin
          m_pos = 0;
          m_frame = (m_frame + 1) % 16;
          done = 1;
          m_bad = 0;
        end
      end
    end
    if (c) begin
      m_frames_ok = 0; m_derr = 0; m_serr = 0; m_err = 0; m_bad = 0;
    end else begin
      if (de) m_derr = sat16(m_derr + 1);
      if (se) m_serr = sat16(m_serr + 1);
      if (de || se) m_err = 1;
      if (done && ok) m_frames_ok = sat16(m_frames_ok + 1);
    end
    if (done) m_done_total++;
    m_mode = nmode;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`ifdef SAXIS_BACKPRESSURE_EN
    e_tready = (m_mode != 0) && (m_lfsr[1:0] != 2'b00);
`else
    e_tready = (m_mode != 0);
`endif
    e_locked = (m_mode == 2);
    e_done   = done;
  endfunction

  function void compare_all();
    chk("tready", 32'(tready), 32'(e_tready));
    chk("locked", 32'(locked), 32'(e_locked));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("frames_ok", 32'(frames_ok), 32'(m_frames_ok));
    chk("data_err_cnt", 32'(data_err_cnt), 32'(m_derr));
    chk("sync_err_cnt", 32'(sync_err_cnt), 32'(m_serr));
    chk("err_flag", 32'(err_flag), 32'(m_err));
    if (frame_done === 1'b1) dut_done++;
  endfunction

  // kind: 0 clean, 1 data corrupted, 2 TLAST flipped, 3 USER flipped at (kl,kw)
  function void push_frame(input int f, input int kind, input int kl, input int kw);
    beat_t b;
    for (int l = 0; l < PV; l++) begin
      for (int w = 0; w < WORDS; w++) begin
        b.d    = {4'(f), 12'(l), 16'h0000} + 32'(w);
        b.last = (w == WORDS - 1);
        b.user = (l == 0 && w == 0);
        if (l == kl && w == kw) begin
          if (kind == 1) b.d = 32'hDEAD_BEEF;
          if (kind == 2) b.last = ~b.last;
          if (kind == 3) b.user = ~b.user;
        end
        q.push_back(b);
      end
    end
  endfunction

  function void push_junk(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = $urandom;
      b.last = 1'($urandom_range(0, 1));
      b.user = 1'b0;
      q.push_back(b);
    end
  endfunction

  task automatic tick(input bit c);
    bit acc;
    if (!have_cur && q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      cur = q.pop_front();
      have_cur = 1;
    end
    tvalid = have_cur;
    tdata  = have_cur ? cur.d : $urandom;
    tlast  = have_cur ? cur.last : 1'b0;
    tuser  = have_cur ? cur.user : 1'b0;
    tstrb  = 4'($urandom_range(0, 15));
    clr    = c;
    acc    = have_cur && e_tready;
    model_step(have_cur, tdata, tlast, tuser, c);
    if (acc) have_cur = 0;
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_frames_ok", 32'(frames_ok), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    model_reset();
    clr = 1'b0;
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic run_queue(input int max_cycles, input int clr_pct, input int reset_at);
    int n;
    n = 0;
    while ((q.size() > 0 || have_cur) && n < max_cycles) begin
      if (n == reset_at) do_reset();
      tick($urandom_range(0, 99) < clr_pct);
      n++;
    end
    chk("drain_budget", 32'(n >= max_cycles), 32'd0);
    tick(1'b0);
    tick(1'b0);
  endtask

  initial begin
    total = 0; bad = 0; dut_done = 0; m_done_total = 0;
    have_cur = 0; gap_pct = 0;
    rst_n = 1'b0; tvalid = 1'b0; tdata = 32'h0; tstrb = 4'h0;
    tlast = 1'b0; tuser = 1'b0; clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    chk("reset_tready", 32'(tready), 32'd0);
    chk("reset_data_err", 32'(data_err_cnt), 32'd0);
    rst_n = 1'b1;

    // Start-up: TVALID high immediately, TREADY held low for START cycles.
    push_junk(3);
    push_frame(1, 0, 0, 0);
    push_frame(2, 0, 0, 0);
    tick(1'b0);
    tick(1'b0);
    chk("startup_tready_low", 32'(tready), 32'd0);
    chk("startup_locked", 32'(locked), 32'd0);
    tick(1'b0);
`ifndef SAXIS_BACKPRESSURE_EN
    chk("startup_tready_high", 32'(tready), 32'd1);
`endif

    // Two clean frames.
    run_queue(1000, 0, -1);
    chk("clean_frames_ok", 32'(frames_ok), 32'd2);
    chk("clean_done_pulses", 32'(dut_done), 32'd2);
    chk("clean_locked", 32'(locked), 32'd1);
    chk("clean_errs", 32'(data_err_cnt) + 32'(sync_err_cnt), 32'd0);

    // Data corruption at line 2, word 1.
    push_frame(3, 1, 2, 1);
    run_queue(1000, 0, -1);
    chk("corrupt_data_err", 32'(data_err_cnt), 32'd1);
    chk("corrupt_err_flag", 32'(err_flag), 32'd1);
    chk("corrupt_frames_ok", 32'(frames_ok), 32'd2);
    chk("corrupt_locked", 32'(locked), 32'd1);

    // Early TLAST at line 1, word 2; the next SOF relocks.
    push_frame(4, 2, 1, 2);
    push_frame(7, 0, 0, 0);
    run_queue(1000, 0, -1);
    chk("tlast_sync_err", 32'(sync_err_cnt), 32'd1);
    chk("tlast_relocked", 32'(locked), 32'd1);
    chk("tlast_frames_ok", 32'(frames_ok), 32'd3);

    // Frame nibble wraps from F to 0 without errors.
    for (int f = 8; f < 18; f++) push_frame(f % 16, 0, 0, 0);
    run_queue(2000, 0, -1);
    chk("wrap_frames_ok", 32'(frames_ok), 32'd13);
    chk("wrap_data_err", 32'(data_err_cnt), 32'd1);
    chk("wrap_done_pulses", 32'(dut_done), 32'd14);
    chk("wrap_model_done", 32'(m_done_total), 32'd14);

    // Clear pulse zeroes counters and flags but keeps the lock.
    tick(1'b1);
    chk("clear_frames_ok", 32'(frames_ok), 32'd0);
    chk("clear_data_err", 32'(data_err_cnt), 32'd0);
    chk("clear_sync_err", 32'(sync_err_cnt), 32'd0);
    chk("clear_err_flag", 32'(err_flag), 32'd0);
    chk("clear_locked", 32'(locked), 32'd1);

    // Randomised frames, gaps, corruptions, clears and a mid-frame reset.
    gap_pct = 20;
    begin
      int f;
      f = 2;
      for (int i = 0; i < 14; i++) begin
        int k;
        k = $urandom_range(0, 9);
        if ($urandom_range(0, 9) == 0) f = $urandom_range(0, 15);
        if ($urandom_range(0, 7) == 0) push_junk($urandom_range(1, 3));
        push_frame(f, (k < 7) ? 0 : (k - 6), $urandom_range(0, PV - 1),
                   $urandom_range(0, WORDS - 1));
        f = (f + 1) % 16;
      end
    end
    run_queue(4000, 2, 45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so a stuck run still terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
